// File: rtl/arb_serial_32_8.sv
// Two-requester round-robin arbiter feeding a shared 32-to-8 serializer.
// Words are granted by valid/ready and emitted as four registered bytes.
module arb_serial_32_8 #(
  parameter bit MSB_FIRST = 1'b1,
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_0,
  input  logic [31:0] data_0,
  output logic        ready_0,
  input  logic        valid_1,
  input  logic [31:0] data_1,
  output logic        ready_1,
  output logic        valid_out,
  output logic [7:0]  data_out,
  output logic        src_id,
  output logic        first_out
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [31:0] word_q, word_d;
  logic        owner_q, owner_d;
  logic        vo_q, vo_d;
  logic [7:0]  do_q, do_d;
  logic        src_q, src_d;
  logic        first_q, first_d;

  logic        window;
  logic        gnt0, gnt1;
  logic [1:0]  idx;
  logic [7:0]  byte_sel;

  always_comb begin
    window = !reset && (state_q == IDLE || cnt_q == 2'd3);
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if (window) begin
      if (valid_0 && valid_1) begin
        if (RR_ENABLE && !last_q) gnt1 = 1'b1;
        else                      gnt0 = 1'b1;
      end else begin
        gnt0 = valid_0;
        gnt1 = valid_1;
      end
    end
  end

  assign ready_0 = gnt0;
  assign ready_1 = gnt1;

  // MSB-first walks byte lanes 3..0, which is the bitwise inverse of cnt
  assign idx      = MSB_FIRST ? ~cnt_q : cnt_q;
  assign byte_sel = word_q[{idx, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    word_d  = word_q;
    owner_d = owner_q;
    vo_d    = 1'b0;
    do_d    = 8'h00;
    src_d   = 1'b0;
    first_d = 1'b0;
    if (state_q == SEND) begin
      vo_d    = 1'b1;
      do_d    = byte_sel;
      src_d   = owner_q;
      first_d = (cnt_q == 2'd0);
      cnt_d   = 2'(cnt_q + 2'd1);
      if (cnt_q == 2'd3) state_d = IDLE;
    end
    if (gnt0 || gnt1) begin
      word_d  = gnt1 ? data_1 : data_0;
      owner_d = gnt1;
      last_d  = gnt1;
      state_d = SEND;
      cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      last_q  <= 1'b1;
      word_q  <= 32'h0;
      owner_q <= 1'b0;
      vo_q    <= 1'b0;
      do_q    <= 8'h00;
      src_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      word_q  <= word_d;
      owner_q <= owner_d;
      vo_q    <= vo_d;
      do_q    <= do_d;
      src_q   <= src_d;
      first_q <= first_d;
    end
  end

  assign valid_out = vo_q;
  assign data_out  = do_q;
  assign src_id    = src_q;
  assign first_out = first_q;

endmodule

// File: tb/tb_arb_serial_32_8.sv
// Directed bench for arb_serial_32_8: default, fixed-priority
// and LSB-first instances share one stimulus set.
module tb_arb_serial_32_8;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_0, valid_1;
  logic [31:0] data_0, data_1;
  logic        r0 [3];
  logic        r1 [3];
  logic        vo [3];
  logic        sid [3];
  logic        fo [3];
  logic [7:0]  dout [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_serial_32_8 #(.MSB_FIRST(1'b1), .RR_ENABLE(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .valid_0(valid_0), .data_0(data_0), .ready_0(r0[0]),
    .valid_1(valid_1), .data_1(data_1), .ready_1(r1[0]),
    .valid_out(vo[0]), .data_out(dout[0]),
    .src_id(sid[0]), .first_out(fo[0])
  );

  arb_serial_32_8 #(.MSB_FIRST(1'b1), .RR_ENABLE(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .valid_0(valid_0), .data_0(data_0), .ready_0(r0[1]),
    .valid_1(valid_1), .data_1(data_1), .ready_1(r1[1]),
    .valid_out(vo[1]), .data_out(dout[1]),
    .src_id(sid[1]), .first_out(fo[1])
  );

  arb_serial_32_8 #(.MSB_FIRST(1'b0), .RR_ENABLE(1'b1)) u_lsb (
    .clk(clk), .reset(reset),
    .valid_0(valid_0), .data_0(data_0), .ready_0(r0[2]),
    .valid_1(valid_1), .data_1(data_1), .ready_1(r1[2]),
    .valid_out(vo[2]), .data_out(dout[2]),
    .src_id(sid[2]), .first_out(fo[2])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {valid_out, src_id, first_out, data_out}
  function automatic logic [31:0] obs(input int k);
    return {21'd0, vo[k], sid[k], fo[k], dout[k]};
  endfunction

  function automatic logic [31:0] ob(input logic v, input logic s,
                                     input logic f, input logic [7:0] d);
    return {21'd0, v, s, f, d};
  endfunction

  task automatic edge_chk(input int k, input string tag,
                          input logic [31:0] exp);
    @(posedge clk);
    #1;
    check(tag, obs(k), exp);
  endtask

  task automatic rdy_chk(input int k, input string tag,
                         input logic e0, input logic e1);
    check({tag, "_rdy"}, {30'd0, r0[k], r1[k]}, {30'd0, e0, e1});
  endtask

  task automatic do_reset;
    reset   = 1'b1;
    valid_0 = 1'b1;
    valid_1 = 1'b1;
    #1;
    rdy_chk(0, "rst_hold0", 1'b0, 1'b0);
    rdy_chk(1, "rst_hold1", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    edge_chk(0, "rst_out", ob(1'b0, 1'b0, 1'b0, 8'h00));
    reset = 1'b0;
  endtask

  // Called one step after the accepting edge; checks 4 bytes and the
  // readies seen in each slot (low for cnt 0..2, given values at cnt 3).
  task automatic xfer_word(input int k, input string tag,
                           input logic [31:0] w, input logic s,
                           input logic msb, input logic drop,
                           input logic e0, input logic e1);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && drop) begin
        valid_0 = 1'b0;
        valid_1 = 1'b0;
      end
      #1;
      if (i < 3) rdy_chk(k, tag, 1'b0, 1'b0);
      else       rdy_chk(k, tag, e0, e1);
      b = msb ? w[8*(3-i) +: 8] : w[8*i +: 8];
      edge_chk(k, tag, ob(1'b1, s, (i == 0), b));
    end
  endtask

  initial begin
    reset   = 1'b1;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    data_0  = 32'h0;
    data_1  = 32'h0;

    // single word from requester 0
    do_reset();
    @(posedge clk);
    #1;
    check("t1_rst2", obs(0), ob(1'b0, 1'b0, 1'b0, 8'h00));
    valid_0 = 1'b1;
    data_0  = 32'hFFFF_FFFF;
    #1;
    rdy_chk(0, "t1_acc", 1'b1, 1'b0);
    edge_chk(0, "t1_lat", ob(1'b0, 1'b0, 1'b0, 8'h00));
    valid_0 = 1'b0;
    xfer_word(0, "t1", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    edge_chk(0, "t1_idle", ob(1'b0, 1'b0, 1'b0, 8'h00));

    // back-to-back words, no bubble
    do_reset();
    valid_0 = 1'b1;
    data_0  = 32'hDDDD_DDDD;
    #1;
    rdy_chk(0, "t2_acc", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    data_0 = 32'h0000_0003;
    xfer_word(0, "t2w0", 32'hDDDD_DDDD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    xfer_word(0, "t2w1", 32'h0000_0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    edge_chk(0, "t2_idle", ob(1'b0, 1'b0, 1'b0, 8'h00));

    // round-robin on sustained contention
    do_reset();
    valid_0 = 1'b1;
    valid_1 = 1'b1;
    data_0  = 32'h1122_3344;
    data_1  = 32'hAABB_CCDD;
    #1;
    rdy_chk(0, "t3_acc", 1'b1, 1'b0);
    edge_chk(0, "t3_lat", ob(1'b0, 1'b0, 1'b0, 8'h00));
    xfer_word(0, "t3w0", 32'h1122_3344, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    xfer_word(0, "t3w1", 32'hAABB_CCDD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    xfer_word(0, "t3w2", 32'h1122_3344, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    xfer_word(0, "t3w3", 32'hAABB_CCDD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    edge_chk(0, "t3_idle", ob(1'b0, 1'b0, 1'b0, 8'h00));

    // fixed priority: requester 0 always wins
    do_reset();
    valid_0 = 1'b1;
    valid_1 = 1'b1;
    #1;
    rdy_chk(1, "t4_acc", 1'b1, 1'b0);
    edge_chk(1, "t4_lat", ob(1'b0, 1'b0, 1'b0, 8'h00));
    xfer_word(1, "t4w0", 32'h1122_3344, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    xfer_word(1, "t4w1", 32'h1122_3344, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    xfer_word(1, "t4w2", 32'h1122_3344, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    edge_chk(1, "t4_idle", ob(1'b0, 1'b0, 1'b0, 8'h00));

    // reset mid-word
    do_reset();
    valid_0 = 1'b1;
    data_0  = 32'h1234_5678;
    data_1  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    valid_0 = 1'b0;
    edge_chk(0, "t5_b0", ob(1'b1, 1'b0, 1'b1, 8'h12));
    edge_chk(0, "t5_b1", ob(1'b1, 1'b0, 1'b0, 8'h34));
    reset   = 1'b1;
    valid_0 = 1'b1;
    valid_1 = 1'b1;
    #1;
    rdy_chk(0, "t5_rst", 1'b0, 1'b0);
    edge_chk(0, "t5_flush", ob(1'b0, 1'b0, 1'b0, 8'h00));
    reset = 1'b0;
    #1;
    rdy_chk(0, "t5_tie", 1'b1, 1'b0);
    edge_chk(0, "t5_lat", ob(1'b0, 1'b0, 1'b0, 8'h00));
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    edge_chk(0, "t5_nb0", ob(1'b1, 1'b0, 1'b1, 8'h12));

    // LSB-first from requester 1
    do_reset();
    valid_1 = 1'b1;
    data_1  = 32'h0000_0003;
    #1;
    rdy_chk(2, "t6_acc", 1'b0, 1'b1);
    edge_chk(2, "t6_lat", ob(1'b0, 1'b0, 1'b0, 8'h00));
    xfer_word(2, "t6", 32'h0000_0003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    edge_chk(2, "t6_idle", ob(1'b0, 1'b0, 1'b0, 8'h00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
